// File: rtl/nrs_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nrs_seq_ctrl
// Purpose  : NRS Gold-sequence controller. Computes c_init, sequences the
//            external x1/x2 LFSRs through load, warm-up and emit, and pairs the
//            emitted bits into QPSK pairs. Macro NRS_PARAM_CHECK_EN enables
//            input range checking with an err pulse.
// Revision : 1.0  initial release
// ============================================================================
module nrs_seq_ctrl #(
  parameter int NC        = 1600,
  parameter int M_OFFSET  = 109,
  parameter int NUM_PAIRS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  cell_id,
  input  logic [4:0]  ns,
  input  logic [2:0]  l,
  input  logic        x1_bit,
  input  logic        x2_bit,
  output logic [27:0] seed,
  output logic        lfsr_init,
  output logic        lfsr_en,
  output logic        lfsr_out,
  output logic [1:0]  c_pair,
  output logic        c_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int c_warm_len = NC + 2 * M_OFFSET;
  localparam int c_warm_w   = $clog2(c_warm_len + 1);
  localparam int c_emit_len = 2 * NUM_PAIRS;
  localparam int c_emit_w   = $clog2(c_emit_len + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_LOAD = 3'd2,
    S_WARM = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [8:0]           r_cell_id;
  logic [4:0]           r_ns;
  logic [2:0]           r_l;
  logic [27:0]          r_seed;
  logic [c_warm_w-1:0]  r_warm_cnt;
  logic [c_emit_w-1:0]  r_emit_cnt;
  logic                 r_even_bit;
  logic [1:0]           r_c_pair;
  logic                 r_c_valid;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_start_ok;
  logic                 w_in_range;
  logic                 w_accept;
  logic                 w_warm_last;
  logic                 w_emit_last;
  logic                 w_c;
  logic                 w_lfsr_init;
  logic                 w_lfsr_en;
  logic                 w_lfsr_out;
  logic [27:0]          w_sym_term;
  logic [27:0]          w_cell_term;
  logic [27:0]          w_prod;
  logic [27:0]          w_seed;

  // A start coinciding with the done pulse is dropped even though the FSM is already idle.
  assign w_start_ok = (r_state == S_IDLE) && start && !r_done;

`ifdef NRS_PARAM_CHECK_EN
  assign w_in_range = (cell_id <= 9'd503) && (ns <= 5'd19) && (l <= 3'd6);
`else
  assign w_in_range = 1'b1;
`endif

  assign w_accept    = w_start_ok && w_in_range;
  assign w_warm_last = (r_warm_cnt == c_warm_w'(c_warm_len - 1));
  assign w_emit_last = (r_emit_cnt == c_emit_w'(c_emit_len - 1));
  assign w_c         = x1_bit ^ x2_bit;

  // c_init = 2^10*(7*(ns+1)+l+1)*(2*cell_id+1) + 2*cell_id + 1, kept to 28 bits
  assign w_sym_term  = 28'd7 * (28'(r_ns) + 28'd1) + 28'(r_l) + 28'd1;
  assign w_cell_term = {18'd0, r_cell_id, 1'b1};
  assign w_prod      = w_sym_term * w_cell_term;
  assign w_seed      = {w_prod[17:0], 10'd0} + w_cell_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_lfsr_init = 1'b0;
    w_lfsr_en   = 1'b0;
    w_lfsr_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CALC;
      end
      S_CALC: begin
        w_next = S_LOAD;
      end
      S_LOAD: begin
        w_lfsr_init = 1'b1;
        w_next      = S_WARM;
      end
      S_WARM: begin
        w_lfsr_en = 1'b1;
        if (w_warm_last) w_next = S_EMIT;
      end
      S_EMIT: begin
        w_lfsr_en  = 1'b1;
        w_lfsr_out = 1'b1;
        if (w_emit_last) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cell_id  <= '0;
      r_ns       <= '0;
      r_l        <= '0;
      r_seed     <= '0;
      r_warm_cnt <= '0;
      r_emit_cnt <= '0;
      r_even_bit <= 1'b0;
      r_c_pair   <= '0;
      r_c_valid  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_c_valid <= 1'b0;
      r_done    <= 1'b0;

      if (w_accept) begin
        r_cell_id <= cell_id;
        r_ns      <= ns;
        r_l       <= l;
        r_busy    <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end

      if (r_state == S_CALC) r_seed <= w_seed;

      if (r_state == S_LOAD) begin
        r_warm_cnt <= '0;
      end else if (r_state == S_WARM) begin
        r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
      end

      // Even bits are staged so c_pair only changes together with c_valid.
      if (r_state == S_WARM) begin
        r_emit_cnt <= '0;
      end else if (r_state == S_EMIT) begin
        r_emit_cnt <= r_emit_cnt + c_emit_w'(1);
        if (!r_emit_cnt[0]) begin
          r_even_bit <= w_c;
        end else begin
          r_c_pair  <= {r_even_bit, w_c};
          r_c_valid <= 1'b1;
        end
        if (w_emit_last) r_done <= 1'b1;
      end
    end
  end

`ifdef NRS_PARAM_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_start_ok && !w_in_range;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign seed      = r_seed;
  assign lfsr_init = w_lfsr_init;
  assign lfsr_en   = w_lfsr_en;
  assign lfsr_out  = w_lfsr_out;
  assign c_pair    = r_c_pair;
  assign c_valid   = r_c_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire
